// File: rtl/proc_run_controller_if.sv
// Harness-side bundle for proc_run_controller.
//   master : test harness / processor side. Drives start, abort, halt_req and
//            retire_valid, and observes the controller outputs.
//   slave  : the controller. Consumes the run requests and drives core_rst,
//            core_en, running, done, timeout, cycle_count and instret_count.
interface proc_run_controller_if #(
   parameter int CNT_W = 32
);
   logic             start;
   logic             abort;
   logic             halt_req;
   logic             retire_valid;
   logic             core_rst;
   logic             core_en;
   logic             running;
   logic             done;
   logic             timeout;
   logic [CNT_W-1:0] cycle_count;
   logic [CNT_W-1:0] instret_count;

   modport master (
      output start, abort, halt_req, retire_valid,
      input  core_rst, core_en, running, done, timeout, cycle_count, instret_count
   );

   modport slave (
      input  start, abort, halt_req, retire_valid,
      output core_rst, core_en, running, done, timeout, cycle_count, instret_count
   );
endinterface

// File: rtl/proc_run_controller.sv
// Run/reset sequencer between the test harness and a processor core.
// Holds the core in reset for RST_CYCLES cycles, enables it for a run that
// ends on halt_req, abort or a MAX_CYCLES budget (0 = no budget), counts
// run cycles and retired instructions (saturating), and latches done/timeout.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous reset, active low
//   bus  - proc_run_controller_if.slave (run requests in, core control and
//          status out); every output is registered.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | core held in reset, waiting for start
// S_RESET | core_rst pulse in progress, rst_cnt counts down to 0
// S_RUN   | core enabled, cycle/instret counters advancing
// S_DONE  | core frozen (no reset, no enable), status held for readout
module proc_run_controller #(
   parameter int CNT_W      = 32,
   parameter int RST_CYCLES = 1,
   parameter int MAX_CYCLES = 19
) (
   input logic                   clk,
   input logic                   rst,
   proc_run_controller_if.slave  bus
);
   typedef enum logic [1:0] {S_IDLE, S_RESET, S_RUN, S_DONE} state_t;

   localparam logic [7:0]       RST_LOAD = 8'(RST_CYCLES - 1);
   localparam logic [CNT_W:0]   MAX_EXT  = (CNT_W+1)'(MAX_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONES = '1;

   state_t           state, state_nxt;
   logic [7:0]       rst_cnt;
   logic [CNT_W-1:0] cycle_cnt, instret_cnt;
   logic             done_q, timeout_q;
   logic             core_rst_q, core_en_q, running_q;
   logic             core_rst_nxt, core_en_nxt, running_nxt;
   logic [CNT_W:0]   cycle_inc;
   logic             budget_hit;

   // One extra bit so a saturated count still compares correctly against the budget.
   assign cycle_inc  = {1'b0, cycle_cnt} + (CNT_W+1)'(1);
   assign budget_hit = (MAX_CYCLES != 0) && (cycle_inc == MAX_EXT);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= S_IDLE;
         core_rst_q <= 1'b1;
         core_en_q  <= 1'b0;
         running_q  <= 1'b0;
      end else begin
         state      <= state_nxt;
         core_rst_q <= core_rst_nxt;
         core_en_q  <= core_en_nxt;
         running_q  <= running_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (bus.start) state_nxt = S_RESET;
         S_RESET: begin
            if (bus.abort)             state_nxt = S_IDLE;
            else if (rst_cnt == 8'd0)  state_nxt = S_RUN;
         end
         S_RUN: begin
            if (bus.abort)                       state_nxt = S_IDLE;
            else if (bus.halt_req || budget_hit) state_nxt = S_DONE;
         end
         S_DONE:  if (bus.start) state_nxt = S_RESET;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Decoded from the next state so the registered outputs line up with the state they describe.
   always_comb begin
      core_rst_nxt = (state_nxt == S_IDLE) || (state_nxt == S_RESET);
      core_en_nxt  = (state_nxt == S_RUN);
      running_nxt  = (state_nxt == S_RUN);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rst_cnt     <= 8'd0;
         cycle_cnt   <= '0;
         instret_cnt <= '0;
         done_q      <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (bus.start) begin
                  rst_cnt     <= RST_LOAD;
                  cycle_cnt   <= '0;
                  instret_cnt <= '0;
                  done_q      <= 1'b0;
                  timeout_q   <= 1'b0;
               end
            end
            S_RESET: begin
               if (rst_cnt != 8'd0) rst_cnt <= rst_cnt - 8'd1;
            end
            S_RUN: begin
               if (cycle_cnt != CNT_ONES) cycle_cnt <= cycle_inc[CNT_W-1:0];
               if (bus.retire_valid && (instret_cnt != CNT_ONES))
                  instret_cnt <= instret_cnt + CNT_W'(1);
               // halt wins over the budget when both land on the same cycle
               if (!bus.abort && (bus.halt_req || budget_hit)) begin
                  done_q    <= 1'b1;
                  timeout_q <= !bus.halt_req;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.core_rst      = core_rst_q;
   assign bus.core_en       = core_en_q;
   assign bus.running       = running_q;
   assign bus.done          = done_q;
   assign bus.timeout       = timeout_q;
   assign bus.cycle_count   = cycle_cnt;
   assign bus.instret_count = instret_cnt;
endmodule

// File: tb/tb_proc_run_controller.sv
module tb_proc_run_controller;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;

   int   sel;
   logic drv_start, drv_abort, drv_halt, drv_retire;
   logic o_core_rst, o_core_en, o_running, o_done, o_timeout;
   logic [31:0] o_cc, o_ic;

   // Per-instance configuration: 0 defaults, 1 long reset/no budget,
   // 2 narrow counters/no budget, 3 one-cycle budget.
   int rst_of[4] = '{1, 4, 1, 3};
   int max_of[4] = '{19, 0, 0, 1};
   int cw_of[4]  = '{32, 32, 4, 32};

   proc_run_controller_if #(.CNT_W(32)) b_def ();
   proc_run_controller_if #(.CNT_W(32)) b_r4  ();
   proc_run_controller_if #(.CNT_W(4))  b_sat ();
   proc_run_controller_if #(.CNT_W(32)) b_m1  ();

   proc_run_controller #(.CNT_W(32), .RST_CYCLES(1), .MAX_CYCLES(19))
      u_def (.clk(clk), .rst(rst), .bus(b_def));
   proc_run_controller #(.CNT_W(32), .RST_CYCLES(4), .MAX_CYCLES(0))
      u_r4  (.clk(clk), .rst(rst), .bus(b_r4));
   proc_run_controller #(.CNT_W(4),  .RST_CYCLES(1), .MAX_CYCLES(0))
      u_sat (.clk(clk), .rst(rst), .bus(b_sat));
   proc_run_controller #(.CNT_W(32), .RST_CYCLES(3), .MAX_CYCLES(1))
      u_m1  (.clk(clk), .rst(rst), .bus(b_m1));

   always_comb begin
      b_def.start = (sel == 0) && drv_start;  b_def.abort = (sel == 0) && drv_abort;
      b_def.halt_req = (sel == 0) && drv_halt; b_def.retire_valid = (sel == 0) && drv_retire;
      b_r4.start = (sel == 1) && drv_start;   b_r4.abort = (sel == 1) && drv_abort;
      b_r4.halt_req = (sel == 1) && drv_halt;  b_r4.retire_valid = (sel == 1) && drv_retire;
      b_sat.start = (sel == 2) && drv_start;  b_sat.abort = (sel == 2) && drv_abort;
      b_sat.halt_req = (sel == 2) && drv_halt; b_sat.retire_valid = (sel == 2) && drv_retire;
      b_m1.start = (sel == 3) && drv_start;   b_m1.abort = (sel == 3) && drv_abort;
      b_m1.halt_req = (sel == 3) && drv_halt;  b_m1.retire_valid = (sel == 3) && drv_retire;
   end

   always_comb begin
      o_core_rst = b_def.core_rst; o_core_en = b_def.core_en; o_running = b_def.running;
      o_done = b_def.done; o_timeout = b_def.timeout;
      o_cc = b_def.cycle_count; o_ic = b_def.instret_count;
      case (sel)
         1: begin
            o_core_rst = b_r4.core_rst; o_core_en = b_r4.core_en; o_running = b_r4.running;
            o_done = b_r4.done; o_timeout = b_r4.timeout;
            o_cc = b_r4.cycle_count; o_ic = b_r4.instret_count;
         end
         2: begin
            o_core_rst = b_sat.core_rst; o_core_en = b_sat.core_en; o_running = b_sat.running;
            o_done = b_sat.done; o_timeout = b_sat.timeout;
            o_cc = {28'd0, b_sat.cycle_count}; o_ic = {28'd0, b_sat.instret_count};
         end
         3: begin
            o_core_rst = b_m1.core_rst; o_core_en = b_m1.core_en; o_running = b_m1.running;
            o_done = b_m1.done; o_timeout = b_m1.timeout;
            o_cc = b_m1.cycle_count; o_ic = b_m1.instret_count;
         end
         default: ;
      endcase
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: a run lasts until the earliest of abort, halt and budget
   // (abort > halt > budget on a tie); every RUN cycle counts, retirements
   // on any RUN cycle count, both counts clamp at the counter maximum.
   task automatic do_run(input int s, input int halt_at, input int abort_at,
                         input logic [31:0] mask, input bit use_mask, input string tag);
      int          rc, end_cyc, sum;
      bit          by_abort, by_halt, r;
      logic [31:0] sat, exp_cc, exp_ic, hold_cc, hold_ic;
      sel = s;
      sat = (cw_of[s] >= 32) ? 32'hffff_ffff : ((32'd1 << cw_of[s]) - 32'd1);
      end_cyc = 100000;
      if (max_of[s] != 0) end_cyc = max_of[s];
      if (halt_at != 0 && halt_at <= end_cyc) end_cyc = halt_at;
      if (abort_at != 0 && abort_at <= end_cyc) end_cyc = abort_at;
      by_abort = (abort_at == end_cyc);
      by_halt  = !by_abort && (halt_at == end_cyc);

      drv_start = 1'b1;
      step();
      drv_start = 1'b0;
      chk({tag, "/clr_done"}, 32'(o_done), 32'd0);
      chk({tag, "/clr_tmo"},  32'(o_timeout), 32'd0);
      chk({tag, "/clr_cc"},   o_cc, 32'd0);
      chk({tag, "/clr_ic"},   o_ic, 32'd0);
      rc = 0;
      while (o_core_rst === 1'b1 && rc < 300) begin
         rc++;
         step();
      end
      chk({tag, "/rst_len"}, 32'(rc), 32'(rst_of[s]));
      chk({tag, "/en_entry"}, 32'(o_core_en), 32'd1);

      sum = 0;
      for (int k = 1; k <= end_cyc; k++) begin
         r = use_mask ? mask[k] : 1'($urandom_range(0, 1));
         if (r) sum++;
         drv_retire = r;
         drv_halt   = (k == halt_at);
         drv_abort  = (k == abort_at);
         step();
         exp_cc = (32'(k) > sat) ? sat : 32'(k);
         exp_ic = (32'(sum) > sat) ? sat : 32'(sum);
         chk($sformatf("%s/cc@%0d", tag, k), o_cc, exp_cc);
         chk($sformatf("%s/ic@%0d", tag, k), o_ic, exp_ic);
         chk($sformatf("%s/running@%0d", tag, k), 32'(o_running), (k < end_cyc) ? 32'd1 : 32'd0);
      end
      drv_retire = 1'b0; drv_halt = 1'b0; drv_abort = 1'b0;
      chk({tag, "/done"},     32'(o_done), by_abort ? 32'd0 : 32'd1);
      chk({tag, "/timeout"},  32'(o_timeout), (!by_abort && !by_halt) ? 32'd1 : 32'd0);
      chk({tag, "/core_en"},  32'(o_core_en), 32'd0);
      chk({tag, "/core_rst"}, 32'(o_core_rst), by_abort ? 32'd1 : 32'd0);

      // abort is ignored outside RESET/RUN; status and counters must hold
      hold_cc = o_cc; hold_ic = o_ic;
      drv_abort = 1'b1; drv_retire = 1'b1;
      step(); step();
      drv_abort = 1'b0; drv_retire = 1'b0;
      chk({tag, "/hold_done"}, 32'(o_done), by_abort ? 32'd0 : 32'd1);
      chk({tag, "/hold_cc"},   o_cc, exp_cc);
      chk({tag, "/hold_ic"},   o_ic, exp_ic);
      chk({tag, "/hold_en"},   32'(o_core_en), 32'd0);
      chk({tag, "/hold_rst"},  32'(o_core_rst), by_abort ? 32'd1 : 32'd0);
      if (hold_cc !== exp_cc || hold_ic !== exp_ic) ; // values already checked above
   endtask

   initial begin
      int s, h, a;
      sel = 0;
      drv_start = 1'b0; drv_abort = 1'b0; drv_halt = 1'b0; drv_retire = 1'b0;

      // reset state, held while start stays low
      rst = 1'b0;
      step(); step();
      rst = 1'b1;
      for (int i = 0; i < 4; i++) step();
      chk("rst/core_rst", 32'(o_core_rst), 32'd1);
      chk("rst/core_en",  32'(o_core_en), 32'd0);
      chk("rst/running",  32'(o_running), 32'd0);
      chk("rst/done",     32'(o_done), 32'd0);
      chk("rst/timeout",  32'(o_timeout), 32'd0);
      chk("rst/cc",       o_cc, 32'd0);
      chk("rst/ic",       o_ic, 32'd0);

      do_run(0, 0, 0, 32'hffff_ffff, 1'b1, "budget");
      do_run(1, 7, 0, 32'h0000_00a4, 1'b1, "halt7");
      do_run(0, 0, 3, 32'h0000_0000, 1'b0, "abort3");
      do_run(0, 19, 0, 32'h0000_0000, 1'b0, "halt_on_budget");
      do_run(2, 22, 0, 32'h0000_0000, 1'b0, "saturate");
      do_run(3, 0, 0, 32'h0000_0002, 1'b1, "max1");
      do_run(3, 1, 0, 32'h0000_0002, 1'b1, "max1_halt");

      // abort during the reset pulse takes priority over entering RUN
      sel = 1;
      drv_start = 1'b1; step(); drv_start = 1'b0;
      drv_abort = 1'b1; step(); drv_abort = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         chk($sformatf("rst_abort/core_en@%0d", i), 32'(o_core_en), 32'd0);
      end
      chk("rst_abort/core_rst", 32'(o_core_rst), 32'd1);

      // synchronous reset in the middle of a run
      sel = 0;
      drv_start = 1'b1; step(); drv_start = 1'b0;
      step();
      drv_retire = 1'b1;
      for (int k = 1; k <= 4; k++) step();
      chk("midrst/cc_before", o_cc, 32'd4);
      rst = 1'b0;
      step();
      rst = 1'b1; drv_retire = 1'b0;
      chk("midrst/core_rst", 32'(o_core_rst), 32'd1);
      chk("midrst/core_en",  32'(o_core_en), 32'd0);
      chk("midrst/running",  32'(o_running), 32'd0);
      chk("midrst/done",     32'(o_done), 32'd0);
      chk("midrst/timeout",  32'(o_timeout), 32'd0);
      chk("midrst/cc",       o_cc, 32'd0);
      chk("midrst/ic",       o_ic, 32'd0);

      for (int i = 0; i < 40; i++) begin
         s = $urandom_range(0, 3);
         h = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 24);
         a = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 24) : 0;
         if (max_of[s] == 0 && h == 0 && a == 0) h = $urandom_range(1, 24);
         do_run(s, h, a, 32'h0, 1'b0, $sformatf("rnd%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule

// File: doc/proc_run_controller.md
Name: proc_run_controller

Overview:
Parametrised run/reset sequencer that sits between the test harness and the processor core. It generates the core's reset pulse with a programmable length, gates the core's run enable, and counts elapsed cycles and retired instructions. It ends a run on a halt request or on a cycle budget, and latches completion status for inspection. It replaces fixed-length, hard-coded reset/clock sequences with a reusable, synthesizable controller.

Parameters:
CNT_W, 32, width of cycle_count and instret_count
RST_CYCLES, 1, number of cycles core_rst is held high in RESET (legal range 1..255)
MAX_CYCLES, 19, cycle budget per run; 0 disables the timeout

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-low
start  input  1  begin a new run (sampled in IDLE or DONE)
abort  input  1  cancel the current run (sampled in RESET or RUN)
halt_req  input  1  processor signals halt/end-of-program
retire_valid  input  1  processor retired one instruction this cycle
core_rst  output  1  active-high reset to processor
core_en  output  1  run enable to processor (1 only in RUN)
running  output  1  high while in RUN
done  output  1  run ended; sticky until next start or rst
timeout  output  1  run ended by cycle budget; sticky like done
cycle_count  output  CNT_W  cycles spent in RUN this run
instret_count  output  CNT_W  retired instructions this run

Behaviour:
- All outputs are registered; state changes take effect on the edge after the sampled input.
- rst==0 at a posedge: state=IDLE, core_rst=1, core_en=0, running=0, done=0, timeout=0, both counters=0. This applies in any state, mid-run included.
- States: IDLE, RESET, RUN, DONE.
- IDLE: core_rst=1, core_en=0.
  - start=1 -> RESET; clear counters, done and timeout; load the internal reset counter with RST_CYCLES-1.
- RESET: core_rst=1, core_en=0.
  - Decrement the reset counter each cycle; when it reaches 0, go to RUN.
  - core_rst is high for exactly RST_CYCLES cycles counted from the RESET entry edge.
  - abort=1 -> IDLE, with priority over the exit to RUN.
- RUN: core_rst=0, core_en=1, running=1.
  - Every RUN cycle: cycle_count+=1.
  - retire_valid=1: instret_count+=1. A retirement in the final (halt/timeout) cycle is counted.
  - Exit priority: abort > halt_req > timeout.
  - abort -> IDLE; counters are kept, done=0.
  - halt_req -> DONE with done=1, timeout=0.
  - MAX_CYCLES!=0 and cycle_count+1==MAX_CYCLES -> DONE with done=1, timeout=1.
  - With no halt, RUN therefore lasts exactly MAX_CYCLES cycles.
- DONE: core_rst=0 and core_en=0, so processor state is frozen for inspection.
  - Counters, done and timeout hold.
  - start=1 -> RESET, clearing status exactly as from IDLE.
  - abort is ignored in DONE.
- start is ignored in RESET and RUN. abort is ignored in IDLE.
- Counters saturate at all-ones and never wrap; a saturated cycle_count does not disable the timeout compare.
- MAX_CYCLES=0: the run ends only on halt_req or abort.
- MAX_CYCLES=1: RUN lasts one cycle, ending with cycle_count=1 and timeout=1 unless halt_req is also high that cycle.

Test Plan:
1. Apply rst=0 for 2 cycles, then rst=1 with start=0 -> core_rst=1, core_en=0, done=0, timeout=0, cycle_count=0, instret_count=0, held indefinitely.
2. Defaults, pulse start for 1 cycle, keep halt_req=0, retire_valid=1 every cycle:
   - core_rst is high 1 cycle.
   - RUN lasts 19 cycles.
   - Finish: done=1, timeout=1, cycle_count=19, instret_count=19, core_en=0.
3. RST_CYCLES=4, MAX_CYCLES=0, start, then halt_req on the 7th RUN cycle with retire_valid on RUN cycles 2, 5, 7:
   - core_rst is high 4 cycles.
   - Finish: done=1, timeout=0, cycle_count=7, instret_count=3.
4. Defaults, start, assert abort on the 3rd RUN cycle -> next state IDLE, core_rst=1, done=0, cycle_count=3. A later start clears cycle_count to 0.
5. Defaults, halt_req=1 on RUN cycle 19 (same cycle the budget expires) -> done=1, timeout=0, cycle_count=19.
6. Drive rst=0 on RUN cycle 5 -> next edge IDLE, all outputs at reset values. CNT_W=4, MAX_CYCLES=0, no halt for 20 RUN cycles -> cycle_count saturates at 15, running stays 1.
